// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bank sequencing controller.
package sram_ctrl_pkg;

  localparam int unsigned SramCtrlNumPorts = 2;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    RETENTIVE = 2'd1,
    WAKE      = 2'd2
  } sram_ctrl_state_e;

  typedef struct packed {
    logic valid;
    logic idx;
  } sram_ctrl_resp_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-input round-robin arbiter; the pointer remembers the last granted port.
module sram_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SramCtrlNumPorts-1:0] req,
  input  logic                        en,
  output logic [SramCtrlNumPorts-1:0] gnt,
  output logic                        idx
);

  logic last;

  always_comb begin
    idx = 1'b0;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = 1'b1;
    end
    gnt = '0;
    if (en && (|req)) begin
      gnt[idx] = 1'b1;
    end
  end

  // Pointer resets to port 1 so that the first contended grant goes to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: round-robin sharing of one bank port plus retention sequencing.
// Optional auto-retention idle counter is built when SRAM_AUTO_RET_EN is defined.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int unsigned NumWords   = 8192,
  parameter  int unsigned IdleCycles = 64,
  parameter  int unsigned WakeCycles = 2,
  localparam int unsigned AddrWidth  = $clog2(NumWords)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [SramCtrlNumPorts-1:0]                req_i,
  input  logic [SramCtrlNumPorts-1:0]                we_i,
  input  logic [SramCtrlNumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic [SramCtrlNumPorts-1:0][31:0]          wdata_i,
  input  logic [SramCtrlNumPorts-1:0][3:0]           be_i,
  output logic [SramCtrlNumPorts-1:0]                gnt_o,
  output logic [SramCtrlNumPorts-1:0]                rvalid_o,
  output logic [31:0]                                rdata_o,
  input  logic                                       force_ret_i,
  output logic                                       ret_o,
  output logic                                       mem_req_o,
  output logic                                       mem_we_o,
  output logic [AddrWidth-1:0]                       mem_addr_o,
  output logic [31:0]                                mem_wdata_o,
  output logic [3:0]                                 mem_be_o,
  output logic                                       mem_set_retentive_no,
  input  logic [31:0]                                mem_rdata_i
);

  localparam int unsigned WakeW = $clog2(WakeCycles + 1);

  if (IdleCycles < 1 || WakeCycles < 1) begin : g_bad_cfg
    $error("sram_bank_ctrl: IdleCycles and WakeCycles must be at least 1");
  end

  sram_ctrl_state_e                  state_q, state_d;
  logic [WakeW-1:0]                  wake_q;
  sram_ctrl_resp_t                   resp_q;
  logic [SramCtrlNumPorts-1:0]       gnt;
  logic                              arb_idx;
  logic                              arb_en;
  logic                              idle;
  logic                              idle_hit;
  logic                              wake_done;

  assign idle      = (req_i == '0);
  assign wake_done = (wake_q == WakeW'(WakeCycles - 1));
  // Grants are gated during reset so the bank sees no access while state clears.
  assign arb_en    = (state_q == ACTIVE) && !force_ret_i && !rst_i;

  sram_rr_arb u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (req_i),
    .en  (arb_en),
    .gnt (gnt),
    .idx (arb_idx)
  );

`ifdef SRAM_AUTO_RET_EN
  localparam int unsigned IdleW = $clog2(IdleCycles + 1);
  logic [IdleW-1:0] idle_q;

  assign idle_hit = idle && (idle_q == IdleW'(IdleCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else if ((state_q == ACTIVE) && idle && (state_d == ACTIVE)) begin
      idle_q <= idle_q + IdleW'(1);
    end else begin
      idle_q <= '0;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE:    if ((force_ret_i && !(|gnt)) || idle_hit) state_d = RETENTIVE;
      RETENTIVE: if ((|req_i) && !force_ret_i) state_d = WAKE;
      WAKE:      if (wake_done) state_d = ACTIVE;
      default:   state_d = ACTIVE;
    endcase
  end

  always_comb begin
    ret_o                = (state_q == RETENTIVE);
    mem_set_retentive_no = (state_q != RETENTIVE);
    gnt_o                = gnt;
    mem_req_o            = |gnt;
    mem_we_o             = (|gnt) && we_i[arb_idx];
    mem_addr_o           = addr_i[arb_idx];
    mem_wdata_o          = wdata_i[arb_idx];
    mem_be_o             = be_i[arb_idx];
    rdata_o              = mem_rdata_i;
    rvalid_o             = '0;
    rvalid_o[resp_q.idx] = resp_q.valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wake_q <= '0;
    end else if ((state_q == WAKE) && (state_d == WAKE)) begin
      wake_q <= wake_q + WakeW'(1);
    end else begin
      wake_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q <= '{valid: |gnt, idx: arb_idx};
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl; the retention section follows SRAM_AUTO_RET_EN.
module tb_sram_bank_ctrl;

  localparam int unsigned AW = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req, we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][31:0]  wdata;
  logic [1:0][3:0]   be;
  logic              force_ret;
  logic [31:0]       mem_rdata;
  logic [1:0]        gnt, rvalid;
  logic [31:0]       rdata, mem_wdata;
  logic              ret, mem_req, mem_we, mem_set_ret_n;
  logic [AW-1:0]     mem_addr;
  logic [3:0]        mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl #(
    .NumWords   (8192),
    .IdleCycles (64),
    .WakeCycles (2)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_i                (req),
    .we_i                 (we),
    .addr_i               (addr),
    .wdata_i              (wdata),
    .be_i                 (be),
    .gnt_o                (gnt),
    .rvalid_o             (rvalid),
    .rdata_o              (rdata),
    .force_ret_i          (force_ret),
    .ret_o                (ret),
    .mem_req_o            (mem_req),
    .mem_we_o             (mem_we),
    .mem_addr_o           (mem_addr),
    .mem_wdata_o          (mem_wdata),
    .mem_be_o             (mem_be),
    .mem_set_retentive_no (mem_set_ret_n),
    .mem_rdata_i          (mem_rdata)
  );

  typedef struct {
    logic [1:0]    req, we;
    logic [AW-1:0] a0, a1;
    logic [31:0]   d0, d1;
    logic [3:0]    b0, b1;
    logic [31:0]   mrd;
    logic [1:0]    e_gnt, e_rvalid;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
    logic [3:0]    e_be;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(
    input logic [1:0] r, input logic [1:0] w,
    input logic [AW-1:0] a0, input logic [AW-1:0] a1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [3:0] b0, input logic [3:0] b1, input logic [31:0] mrd,
    input logic [1:0] eg, input logic [1:0] erv, input logic ewe,
    input logic [AW-1:0] ea, input logic [31:0] ed, input logic [3:0] eb);
    vec_t v;
    v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.b0 = b0; v.b1 = b1; v.mrd = mrd; v.e_gnt = eg; v.e_rvalid = erv;
    v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed; v.e_be = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
  task automatic step(input logic [1:0] r, input logic f, input logic rs);
    @(posedge clk);
    #1;
    req = r; force_ret = f; rst = rs;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    force_ret = 1'b0; mem_rdata = '0;

    vecs[0] = mk(2'b01, 2'b00, 13'h010, 13'h000, 32'h0, 32'h0, 4'hF, 4'hF, 32'h12345678,
                 2'b01, 2'b00, 1'b0, 13'h010, 32'h0, 4'hF);
    vecs[1] = mk(2'b00, 2'b00, 13'h000, 13'h000, 32'h0, 32'h0, 4'h0, 4'h0, 32'hDEADBEEF,
                 2'b00, 2'b01, 1'b0, 13'h000, 32'h0, 4'h0);
    vecs[2] = mk(2'b10, 2'b10, 13'h000, 13'h1FFF, 32'h0, 32'hCAFEF00D, 4'h0, 4'hF, 32'h0,
                 2'b10, 2'b00, 1'b1, 13'h1FFF, 32'hCAFEF00D, 4'hF);
    vecs[3] = mk(2'b11, 2'b01, 13'h000, 13'h022, 32'h11111111, 32'h22222222, 4'h3, 4'hC, 32'hA5A5A5A5,
                 2'b01, 2'b10, 1'b1, 13'h000, 32'h11111111, 4'h3);
    vecs[4] = mk(2'b11, 2'b01, 13'h000, 13'h022, 32'h11111111, 32'h22222222, 4'h3, 4'hC, 32'h5A5A5A5A,
                 2'b10, 2'b01, 1'b0, 13'h022, 32'h22222222, 4'hC);
    vecs[5] = mk(2'b11, 2'b01, 13'h000, 13'h022, 32'h11111111, 32'h22222222, 4'h3, 4'hC, 32'h0F0F0F0F,
                 2'b01, 2'b10, 1'b1, 13'h000, 32'h11111111, 4'h3);
    vecs[6] = mk(2'b00, 2'b00, 13'h000, 13'h000, 32'h0, 32'h0, 4'h0, 4'h0, 32'hFFFFFFFF,
                 2'b00, 2'b01, 1'b0, 13'h000, 32'h0, 4'h0);

    // Reset values, with requests and writes already presented.
    repeat (2) @(posedge clk);
    #1;
    req = 2'b11; we = 2'b11; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ret", 32'(ret), 32'h0);
    chk("rst_set_ret_n", 32'(mem_set_ret_n), 32'h1);
    chk("rst_rdata", rdata, 32'h13579BDF);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = 1'b0; force_ret = 1'b0;
      req = vecs[i].req; we = vecs[i].we;
      addr[0] = vecs[i].a0; addr[1] = vecs[i].a1;
      wdata[0] = vecs[i].d0; wdata[1] = vecs[i].d1;
      be[0] = vecs[i].b0; be[1] = vecs[i].b1;
      mem_rdata = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].e_rvalid));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(|vecs[i].e_gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].mrd);
      if (|vecs[i].e_gnt) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vecs[i].e_be));
      end
    end

    // Force retention right after a grant: pending response still delivered.
    we = '0; addr[0] = 13'h040; addr[1] = 13'h041;
    step(2'b01, 1'b0, 1'b0);
    chk("frc_gnt0", 32'(gnt), 32'h1);
    step(2'b00, 1'b1, 1'b0);
    chk("frc_gnt_supp", 32'(gnt), 32'h0);
    chk("frc_rvalid", 32'(rvalid), 32'h1);
    chk("frc_not_ret_yet", 32'(ret), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 1'b1, 1'b0);
      chk($sformatf("frc_hold%0d_ret", k), 32'(ret), 32'h1);
      chk($sformatf("frc_hold%0d_set_n", k), 32'(mem_set_ret_n), 32'h0);
      chk($sformatf("frc_hold%0d_gnt", k), 32'(gnt), 32'h0);
    end
    step(2'b01, 1'b0, 1'b0);
    chk("frc_rel_ret", 32'(ret), 32'h1);
    chk("frc_rel_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(2'b01, 1'b0, 1'b0);
      chk($sformatf("wake%0d_ret", k), 32'(ret), 32'h0);
      chk($sformatf("wake%0d_set_n", k), 32'(mem_set_ret_n), 32'h1);
      chk($sformatf("wake%0d_gnt", k), 32'(gnt), 32'h0);
    end
    step(2'b01, 1'b0, 1'b0);
    chk("wake_done_gnt", 32'(gnt), 32'h1);
    chk("wake_done_addr", 32'(mem_addr), 32'h040);

    // Reset between a grant and its response.
    step(2'b01, 1'b0, 1'b0);
    chk("mrst_pre_gnt", 32'(gnt), 32'h1);
    step(2'b01, 1'b0, 1'b1);
    chk("mrst_gnt", 32'(gnt), 32'h0);
    step(2'b11, 1'b0, 1'b0);
    chk("mrst_rvalid", 32'(rvalid), 32'h0);
    chk("mrst_ret", 32'(ret), 32'h0);
    chk("mrst_first_gnt", 32'(gnt), 32'h1);
    step(2'b11, 1'b0, 1'b0);
    chk("mrst_second_gnt", 32'(gnt), 32'h2);
    chk("mrst_second_rvalid", 32'(rvalid), 32'h1);

`ifdef SRAM_AUTO_RET_EN
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      step(2'b00, 1'b0, 1'b0);
      if (k == 1) chk("idle_rvalid", 32'(rvalid), 32'h2);
      if (k < 64 && ret !== 1'b0) bad++;
    end
    chk("idle_early_ret", 32'(bad), 32'h0);
    chk("idle64_ret", 32'(ret), 32'h0);
    step(2'b00, 1'b0, 1'b0);
    chk("idle65_ret", 32'(ret), 32'h1);
    chk("idle65_set_n", 32'(mem_set_ret_n), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 1'b0, 1'b0);
      chk($sformatf("aw%0d_gnt", k), 32'(gnt), 32'h0);
    end
    step(2'b10, 1'b0, 1'b0);
    chk("aw_gnt", 32'(gnt), 32'h2);
    step(2'b00, 1'b0, 1'b0);
    chk("aw_rvalid", 32'(rvalid), 32'h2);
`else
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      step(2'b00, 1'b0, 1'b0);
      if (k == 1) chk("idle_rvalid", 32'(rvalid), 32'h2);
      if (ret !== 1'b0 || mem_set_ret_n !== 1'b1) bad++;
    end
    chk("noret_cycles", 32'(bad), 32'h0);
    chk("noret_ret", 32'(ret), 32'h0);
    step(2'b10, 1'b0, 1'b0);
    chk("noret_gnt", 32'(gnt), 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
